// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with word-addressed data memory and MEM/WB register.
// Define SRAM_WAIT_EN to add a wait-state FSM that freezes the pipeline for WAIT_CYCLES per access.
module mem_stage #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res_MEM,
    input  logic [31:0] rm_val_MEM,
    input  logic [3:0]  dest_MEM,
    input  logic        WB_EN_MEM,
    input  logic        MEM_R_EN_MEM,
    input  logic        MEM_W_EN_MEM,
    output logic [31:0] alu_res_WB,
    output logic [31:0] mem_data_WB,
    output logic [3:0]  dest_WB,
    output logic        WB_EN_WB,
    output logic        MEM_R_EN_WB,
    output logic [31:0] val_WB,
    output logic        freeze
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LO = 32'(BASE_ADDR);
    localparam logic [31:0] HI = 32'(BASE_ADDR + 4 * DEPTH);

    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
        $error("mem_stage: WAIT_CYCLES must be >= 1");
    end

    // Contents are not touched by reset; zero only as the power-up value.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic [31:0] off;
    logic [AW-1:0] idx;
    logic in_range, is_ld, commit;

    always_comb begin
        off      = alu_res_MEM - LO;
        idx      = AW'(off >> 2);
        in_range = (alu_res_MEM >= LO) && (alu_res_MEM < HI);
        is_ld    = MEM_R_EN_MEM & ~MEM_W_EN_MEM;
        commit   = ~freeze;
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && MEM_W_EN_MEM && in_range)
            mem[idx] <= rm_val_MEM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_res_WB  <= '0;
            mem_data_WB <= '0;
            dest_WB     <= '0;
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
        end else if (commit) begin
            alu_res_WB  <= alu_res_MEM;
            mem_data_WB <= (is_ld && in_range) ? mem[idx] : '0;
            dest_WB     <= dest_MEM;
            WB_EN_WB    <= WB_EN_MEM;
            MEM_R_EN_WB <= is_ld;
        end else begin
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
        end
    end

    assign val_WB = MEM_R_EN_WB ? mem_data_WB : alu_res_WB;

`ifdef SRAM_WAIT_EN
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic access;

    assign access = MEM_R_EN_MEM | MEM_W_EN_MEM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Freeze covers IDLE plus WAIT_CYCLES-1 WAIT cycles; DONE is the commit cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        freeze  = 1'b0;
        case (state)
            IDLE: if (access) begin
                freeze  = 1'b1;
                cnt_n   = CW'(1);
                state_n = (WAIT_CYCLES == 1) ? DONE : WAIT;
            end
            WAIT: begin
                freeze = 1'b1;
                cnt_n  = cnt + 1'b1;
                if (cnt == CW'(WAIT_CYCLES - 1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
`else
    assign freeze = 1'b0;
`endif
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit data-memory words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024, meaning the byte address that maps to word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 3, legal range >=1, meaning freeze cycles per access when wait states are compiled in.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 alu_res_MEM  in  32  effective address, or ALU result to pass through.
REQ-007 rm_val_MEM  in  32  store data.
REQ-008 dest_MEM  in  4  destination register.
REQ-009 WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM  in  1 each  write-back enable, load, store.
REQ-010 alu_res_WB, mem_data_WB  out  32 each  registered ALU result and load data.
REQ-011 dest_WB  out  4; WB_EN_WB, MEM_R_EN_WB  out  1 each  registered controls.
REQ-012 val_WB  out  32  combinational write-back value: mem_data_WB if MEM_R_EN_WB, else alu_res_WB; also feeds the EXE forwarding muxes.
REQ-013 freeze  out  1  stall request to IF/ID/EXE and their pipeline registers.

Function
REQ-014 Word index SHALL be (alu_res_MEM - BASE_ADDR) >> 2; address bits [1:0] are ignored.
REQ-015 An address below BASE_ADDR or at/above BASE_ADDR + 4*DEPTH SHALL be out of range: the store is dropped, and the load returns 32'h0.
REQ-016 A store SHALL write rm_val_MEM exactly once per instruction, on the commit edge.
REQ-017 A load SHALL capture the word at the index into mem_data_WB on the commit edge; a store or a non-memory instruction SHALL capture 0 into mem_data_WB.
REQ-018 On each non-stalled edge, the MEM/WB register SHALL load alu_res, dest, WB_EN and MEM_R_EN from the MEM-side inputs.
REQ-019 On each edge where freeze=1, the MEM/WB register SHALL load a bubble: WB_EN_WB=0, MEM_R_EN_WB=0, and other fields unchanged.
REQ-020 If MEM_R_EN_MEM and MEM_W_EN_MEM are both high, the instruction SHALL be treated as a store only, and MEM_R_EN_WB SHALL be 0.
REQ-021 The data memory SHALL be uninitialised by reset; the simulation model SHALL initialise every word to 0 at time zero.

Reset
REQ-022 With rst high at an edge, the following SHALL be cleared: alu_res_WB, mem_data_WB, dest_WB, WB_EN_WB, MEM_R_EN_WB; the FSM SHALL return to IDLE.
REQ-023 The edge at which rst is high SHALL NOT commit a store, even if a store is pending or in progress.
REQ-024 In the first cycle after reset, freeze SHALL be 0 unless the current MEM inputs request an access (IDLE behaviour).

Configuration
REQ-025 The macro SHALL be SRAM_WAIT_EN.
REQ-026 Without SRAM_WAIT_EN: freeze is tied to 0, and every access commits on the edge ending the cycle it is presented (latency 1).
REQ-027 With SRAM_WAIT_EN, the block SHALL implement an FSM with states IDLE, WAIT, DONE and a counter of width clog2(WAIT_CYCLES+1).
REQ-028 In IDLE with (MEM_R_EN_MEM|MEM_W_EN_MEM) high: freeze=1; the FSM SHALL go to WAIT with cnt=1, or directly to DONE if WAIT_CYCLES=1.
REQ-029 In WAIT: freeze=1 and cnt increments; the FSM SHALL go to DONE when cnt==WAIT_CYCLES-1.
REQ-030 In DONE: freeze=0; the access commits per REQ-016/017 and the FSM SHALL return to IDLE.
REQ-031 A back-to-back memory instruction arriving after DONE SHALL restart the sequence from IDLE.
REQ-032 With SRAM_WAIT_EN, the block SHALL assert freeze for exactly WAIT_CYCLES cycles per access, and access latency SHALL be WAIT_CYCLES+1 cycles.
REQ-033 With SRAM_WAIT_EN, a non-memory instruction in IDLE SHALL pass with no freeze.
REQ-034 Upstream SHALL hold the MEM inputs stable while freeze=1; the block SHALL sample them only at commit.

Verification
REQ-035 Store then load, no macro: STR 32'hDEADBEEF @1028, then LDR @1028 -> next cycle MEM_R_EN_WB=1 and val_WB=32'hDEADBEEF.
REQ-036 Out of range: STR 32'h1234 @1020, then LDR @1020 and LDR @1280 -> mem_data_WB=0 for both, and no word is modified.
REQ-037 Wait states, WAIT_CYCLES=3: LDR @1024 -> freeze high exactly 3 cycles; WB_EN_WB=0 during those cycles; data valid on the 4th edge.
REQ-038 Back-to-back with the macro: STR, STR, ADD -> freeze pattern 1,1,1,0,1,1,1,0,0, and each word is written once.
REQ-039 Reset mid-access: rst during WAIT of a STR @1032 -> word at 1032 unchanged, freeze=0 after reset, all WB outputs 0.
REQ-040 Pass-through: ADD with alu_res=32'h55, dest=4'd7, WB_EN=1 -> next cycle val_WB=32'h55, dest_WB=7, WB_EN_WB=1.
